pattern_rotator: RTL
====================

// Module: pattern_rotator
// PURPOSE
//  Parametrised circular register bank that rotates SIZE entries of WIDTH bits in either direction.
//  Rotation is free-running at a programmable rate, or single-stepped; entries are loadable while idle.
//  Tracks rotation position and flags each full revolution.
//  Drives scrolling display/LED pattern paths; successor to the fixed 8x16 rotator.
// PARAMETERS
//  WIDTH  8    bits per entry
//  SIZE   16   number of entries (>=2)
//  DIV_W  16   width of rate-divider compare value
//  INIT   '0   packed [SIZE*WIDTH-1:0] reset pattern; entry i = INIT[i*WIDTH +: WIDTH]
// PORTS
//  clk      in   1             system clock
//  rst      in   1             synchronous, active-high reset
//  start    in   1             pulse: IDLE -> RUN
//  stop     in   1             pulse: RUN/SINGLE -> IDLE
//  step     in   1             pulse: in IDLE, perform exactly one rotation
//  dir      in   1             0 = up (new[i]=old[i-1], new[0]=old[SIZE-1]); 1 = down (new[i]=old[i+1], new[SIZE-1]=old[0])
//  div_val  in   DIV_W         RUN mode: one rotation every div_val+1 cycles
//  wr_en    in   1             write request
//  wr_addr  in   $clog2(SIZE)  entry index to write
//  wr_data  in   WIDTH         write data
//  wr_ack   out  1             1-cycle pulse: write accepted
//  wr_err   out  1             1-cycle pulse: write rejected (not IDLE, or wr_addr >= SIZE)
//  busy     out  1             1 when state != IDLE
//  pos      out  $clog2(SIZE)  rotation offset, mod SIZE
//  wrap     out  1             1-cycle pulse on the rotation that brings pos to 0
//  reg_out  out  [WIDTH-1:0] x [SIZE]  current entries, registered
// BEHAVIOUR
//  - One clock, clk. Reset is synchronous and active-high (rst).
//  - Reset (any state, mid-operation included): state=IDLE; reg_out=INIT; pos=0; divider count=0;
//    wr_ack=wr_err=wrap=0; busy=0.
//  - FSM states: IDLE, RUN, SINGLE.
//    - IDLE + start -> RUN.
//    - IDLE + step (no start) -> SINGLE.
//    - SINGLE: rotate once this cycle -> IDLE.
//    - RUN + stop -> IDLE.
//    - SINGLE + stop -> IDLE, no rotation.
//    - Precedence: stop > start > step. start in RUN and step in RUN are ignored.
//  - RUN: divider counts 0..div_val. A rotation occurs on the cycle count==div_val, then count=0.
//    - div_val=0: rotate every cycle.
//    - div_val is sampled each cycle; if it is lowered below count, rotate on the next cycle and restart.
//    - Divider is cleared on entry to RUN. First rotation occurs div_val+1 cycles after start.
//  - Rotation uses dir sampled on the rotating cycle. reg_out and pos update on the following edge (latency 1).
//  - pos: +1 mod SIZE on up rotation, -1 mod SIZE on down rotation.
//    - wrap=1 for the cycle after a rotation that makes pos==0, in either direction.
//  - Writes:
//    - Accepted only in IDLE with wr_addr<SIZE: entry updated next edge, wr_ack=1.
//    - Otherwise no update, wr_err=1.
//    - A write in the same cycle as start/step is accepted; the write lands before the first rotation.
//    - Writes do not change pos.
//  - busy, wr_ack, wr_err and wrap are all registered.
// STRUCTURE
//  - pattern_rotator_pkg holds:
//    - state_t enum {IDLE, RUN, SINGLE}
//    - dir_t enum {DIR_UP, DIR_DOWN}
//    - function rotate(), a pure array rotate used by RTL and the reference model
//  - Sub-module rate_divider (DIV_W): inputs clk, rst, clr, en, div_val; output tick.
//  - Top holds the FSM, register array, pos counter and write port.
// TESTING (WIDTH=8, SIZE=16, INIT = entry i holds i)
//  1. Reset, hold 5 cycles -> reg_out[i]==i, pos==0, busy==0, no pulses.
//  2. div_val=0, dir=0, start, 16 cycles
//     -> after 1st rotation reg_out[0]==15 and reg_out[1]==0; pos counts 1..15,0;
//        wrap pulses exactly once, on the 16th rotation.
//  3. div_val=3, dir=1, start -> rotations every 4 cycles; after one rotation reg_out[15]==0, pos==15;
//     stop then asserted -> contents frozen, busy==0 next cycle.
//  4. In IDLE: wr_en, addr=5, data=8'hA5 -> wr_ack, reg_out[5]==8'hA5.
//     Same write during RUN -> wr_err, no change.
//     addr=16 with SIZE=16 is unreachable; use a SIZE=12 build with addr=13 -> wr_err.
//  5. step with dir=0 -> exactly one rotation, pos==1, back to IDLE.
//     step+start together -> RUN. stop+start together in IDLE -> stays IDLE.
//  6. rst asserted mid-RUN, with pos==7 and a write pending
//     -> next cycle reg_out==INIT, pos==0, IDLE, no wr_ack.

Source files
------------

// File: rtl/pattern_rotator_pkg.sv
// Shared types and the array-rotate helper for the pattern rotator.
// The rotate function works on a flat vector so that any WIDTH x SIZE bank can use it.
package pattern_rotator_pkg;

   typedef enum logic [1:0] {IDLE, RUN, SINGLE} state_t;
   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

   // Upper bound on WIDTH*SIZE supported by rotate().
   localparam int MAX_BITS  = 2048;
   localparam int MAX_IDX_W = $clog2(MAX_BITS);

   // Up: entry i takes entry i-1 (entry 0 takes the last); down is the mirror image.
   function automatic logic [MAX_BITS-1:0] rotate(input logic [MAX_BITS-1:0] vec,
                                                  input int size, input int width,
                                                  input dir_t dir);
      logic [MAX_BITS-1:0]  res;
      logic [MAX_IDX_W-1:0] src;
      int                   total;
      res   = '0;
      total = size * width;
      for (int b = 0; b < MAX_BITS; b++) begin
         if (b < total) begin
            if (dir == DIR_UP)
               src = MAX_IDX_W'((b >= width) ? b - width : b - width + total);
            else
               src = MAX_IDX_W'((b + width < total) ? b + width : b + width - total);
            res[MAX_IDX_W'(b)] = vec[src];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/pattern_rotator_if.sv
// Control, write-port and status bundle of the pattern rotator.
// master drives commands and writes; slave is the rotator itself.
interface pattern_rotator_if #(
   parameter int WIDTH = 8,
   parameter int SIZE  = 16,
   parameter int DIV_W = 16
) ();

   localparam int ADDR_W = $clog2(SIZE);

   logic              start;
   logic              stop;
   logic              step;
   logic              dir;
   logic [DIV_W-1:0]  div_val;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              wr_ack;
   logic              wr_err;
   logic              busy;
   logic [ADDR_W-1:0] pos;
   logic              wrap;
   logic [WIDTH-1:0]  reg_out [SIZE];

   modport master (
      output start, stop, step, dir, div_val, wr_en, wr_addr, wr_data,
      input  wr_ack, wr_err, busy, pos, wrap, reg_out
   );

   modport slave (
      input  start, stop, step, dir, div_val, wr_en, wr_addr, wr_data,
      output wr_ack, wr_err, busy, pos, wrap, reg_out
   );

endinterface

// File: rtl/pattern_rotator_rate_divider.sv
// Programmable rate divider: ticks once every div_val+1 enabled cycles.
// clr holds the count at zero so each RUN period starts from a clean phase.
module rate_divider #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [DIV_W-1:0] div_val,
   output logic             tick
);

   logic [DIV_W-1:0] count_q;
   logic [DIV_W-1:0] count_d;

   // >= rather than == so a div_val lowered below the count still ticks and restarts.
   assign tick = en && (count_q >= div_val);

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (en)
         count_d = tick ? '0 : count_q + DIV_W'(1);
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
      if (rst)
         count_q <= '0;
      else
         count_q <= count_d;
   end

endmodule

// File: rtl/pattern_rotator.sv
// Circular WIDTH x SIZE register bank rotating up or down, free-running or single-stepped.
// Holds the control FSM, the register array, the position counter and the write port.
module pattern_rotator
   import pattern_rotator_pkg::*;
#(
   parameter int                    WIDTH = 8,
   parameter int                    SIZE  = 16,
   parameter int                    DIV_W = 16,
   parameter logic [SIZE*WIDTH-1:0] INIT  = '0
) (
   input logic               clk,
   input logic               rst,
   pattern_rotator_if.slave  bus
);

   localparam int ADDR_W = $clog2(SIZE);
   localparam int TOTAL  = SIZE * WIDTH;

   state_t            state_q;
   state_t            state_d;
   logic [TOTAL-1:0]  regs_q;
   logic [TOTAL-1:0]  regs_d;
   logic [ADDR_W-1:0] pos_q;
   logic [ADDR_W-1:0] pos_d;
   logic              busy_q;
   logic              wr_ack_q;
   logic              wr_err_q;
   logic              wrap_q;

   logic              tick;
   logic              rotate_en;
   logic              wr_ok;
   dir_t              dir_s;

   assign dir_s = dir_t'(bus.dir);

   rate_divider #(
      .DIV_W (DIV_W)
   ) u_div (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q != RUN),
      .en      (state_q == RUN),
      .div_val (bus.div_val),
      .tick    (tick)
   );

   // Precedence in IDLE is stop > start > step; stop also cancels a pending single step.
   always_comb begin
      state_d   = state_q;
      rotate_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!bus.stop) begin
               if (bus.start)
                  state_d = RUN;
               else if (bus.step)
                  state_d = SINGLE;
            end
         end
         RUN: begin
            if (bus.stop)
               state_d = IDLE;
            else
               rotate_en = tick;
         end
         SINGLE: begin
            state_d   = IDLE;
            rotate_en = !bus.stop;
         end
         default: state_d = IDLE;
      endcase
   end

   assign wr_ok = bus.wr_en && (state_q == IDLE) && (int'(bus.wr_addr) < SIZE);

   // Rotation and an accepted write never share a cycle: writes are IDLE-only.
   always_comb begin
      regs_d = regs_q;
      pos_d  = pos_q;
      if (rotate_en) begin
         regs_d = TOTAL'(rotate(MAX_BITS'(regs_q), SIZE, WIDTH, dir_s));
         if (dir_s == DIR_DOWN)
            pos_d = (pos_q == '0) ? ADDR_W'(SIZE - 1) : pos_q - ADDR_W'(1);
         else
            pos_d = (pos_q == ADDR_W'(SIZE - 1)) ? '0 : pos_q + ADDR_W'(1);
      end
      if (wr_ok)
         regs_d[int'(bus.wr_addr) * WIDTH +: WIDTH] = bus.wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the bank is real flops with a defined power-on pattern, so it is reset like any other state.
         state_q  <= IDLE;
         regs_q   <= INIT;
         pos_q    <= '0;
         busy_q   <= 1'b0;
         wr_ack_q <= 1'b0;
         wr_err_q <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         regs_q   <= regs_d;
         pos_q    <= pos_d;
         busy_q   <= (state_d != IDLE);
         wr_ack_q <= wr_ok;
         wr_err_q <= bus.wr_en && !wr_ok;
         wrap_q   <= rotate_en && (pos_d == '0);
      end
   end

   assign bus.busy   = busy_q;
   assign bus.wr_ack = wr_ack_q;
   assign bus.wr_err = wr_err_q;
   assign bus.wrap   = wrap_q;
   assign bus.pos    = pos_q;

   for (genvar g = 0; g < SIZE; g++) begin : g_out
      assign bus.reg_out[g] = regs_q[g*WIDTH +: WIDTH];
   end

endmodule
